key_debounce: RTL and testbench

- Input-side companion to the board LED blinker: conditions KEY_W mechanical push-buttons into clean, synchronous events for control logic on the 100 MHz domain.
- Per key: 2-flop synchronizer, polarity normalisation, debounce FSM.
- Per-key outputs: a debounced level plus single-cycle pulses for press, release and long-press.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_debounce_ch.sv | 119 +++++++++++
 rtl/key_debounce.sv | 54 +++++
 tb/tb_key_debounce.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Purpose: shared state encoding and default timing for the key debounce block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_pkg;

    // Debounce FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_DEB   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_DEB = 2'd3
    } key_st_e;

    // Default timing at 100 MHz: 20 ms debounce, 1 s long-press.
    localparam int DEB_20MS = 2_000_000;
    localparam int LONG_1S  = 100_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// Purpose: one key channel: 2-flop synchronizer, polarity fix, debounce FSM, hold timer.
// Latency: press/release pulses 2+DEB_CNT clocks after a stable pad change; long pulse LONG_CNT after press.
// Backpressure: none; the pad is sampled every clock and pulses are never held off.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CNT    = DEB_20MS,
    parameter int LONG_CNT   = LONG_1S,
    parameter int CNT_W      = 28,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_100M,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);
    localparam logic             REL_LVL   = ACTIVE_LOW;

    logic             ff1;
    logic             ff2;
    logic             pr;
    key_st_e          state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;

    // Synchronize the asynchronous pad; flops rest at the released pad level.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= REL_LVL;
            ff2 <= REL_LVL;
        end else begin
            ff1 <= key_in;
            ff2 <= ff1;
        end
    end

    // Normalised level: 1 = pressed regardless of pad polarity.
    assign pr = ff2 ^ REL_LVL;

    // Debounce FSM with hold timer; all outputs registered, pulses default low.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;

            // Hold time keeps running through release bounces so long-press
            // timing is not disturbed by a brief glitch.
            if (state == ST_PRESSED || state == ST_RELEASE_DEB) begin
                if (hold_cnt != LONG_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                if (hold_cnt == LONG_LAST && !long_done) begin
                    key_long  <= 1'b1;
                    long_done <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pr) begin
                        state   <= ST_PRESS_DEB;
                        deb_cnt <= '0;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!pr) begin
                        state <= ST_IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= ST_PRESSED;
                        key_state <= 1'b1;
                        key_press <= 1'b1;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!pr) begin
                        state   <= ST_RELEASE_DEB;
                        deb_cnt <= '0;
                    end
                end
                ST_RELEASE_DEB: begin
                    if (pr) begin
                        state <= ST_PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= ST_IDLE;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Purpose: KEY_W independent push-button conditioners with parameter sanity checks.
// Latency: per channel, 2+DEB_CNT clocks pad-to-pulse; long pulse LONG_CNT after press.
// Backpressure: none; channels run freely and independently.
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W      = 2,
    parameter int DEB_CNT    = DEB_20MS,
    parameter int LONG_CNT   = LONG_1S,
    parameter int CNT_W      = 28,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long
);

    // Reject parameter sets the counters cannot honour.
    if (KEY_W < 1) begin : g_chk_key_w
        $error("key_debounce: KEY_W must be >= 1");
    end
    if (DEB_CNT < 2) begin : g_chk_deb
        $error("key_debounce: DEB_CNT must be >= 2");
    end
    if (LONG_CNT <= DEB_CNT) begin : g_chk_long
        $error("key_debounce: LONG_CNT must exceed DEB_CNT");
    end
    if (longint'(LONG_CNT) > ((longint'(1) << CNT_W) - 1)) begin : g_chk_cnt_w
        $error("key_debounce: CNT_W too narrow for LONG_CNT");
    end

    // One self-contained conditioner per key.
    for (genvar g = 0; g < KEY_W; g++) begin : g_ch
        key_debounce_ch #(
            .DEB_CNT    (DEB_CNT),
            .LONG_CNT   (LONG_CNT),
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk_100M    (clk_100M),
            .rst_n       (rst_n),
            .key_in      (key_in[g]),
            .key_state   (key_state[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Purpose: randomized and directed checking of key_debounce against a run-length model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_key_debounce;

    localparam int KW  = 2;
    localparam int DEB = 4;
    localparam int LNG = 16;
    localparam int CW  = 8;

    logic          clk_100M = 1'b0;
    logic          rst_n    = 1'b0;
    logic [KW-1:0] key_in   = '1;
    logic [KW-1:0] key_state;
    logic [KW-1:0] key_press;
    logic [KW-1:0] key_release;
    logic [KW-1:0] key_long;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: pad delay line, debounced level, run of disagreeing samples, press time.
    bit m_s1  [KW];
    bit m_s2  [KW];
    bit m_lvl [KW];
    int m_run [KW];
    int m_pt  [KW];

    always #5 clk_100M = ~clk_100M;

    key_debounce #(
        .KEY_W      (KW),
        .DEB_CNT    (DEB),
        .LONG_CNT   (LNG),
        .CNT_W      (CW),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Wait for bit idx of an output (0 state, 1 press, 2 release, 3 long) within budget.
    task automatic wait_bit(input int sel, input int idx, input int budget, output int at);
        logic [KW-1:0] v;
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk_100M);
            #2;
            case (sel)
                0:       v = key_state;
                1:       v = key_press;
                2:       v = key_release;
                default: v = key_long;
            endcase
            if (v[idx]) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_timeout sel=%0d idx=%0d actual=none required=pulse cyc=%0d", sel, idx, cyc);
    endtask

    // Per-edge model step and full output comparison.
    always @(posedge clk_100M) begin
        logic [KW-1:0] kin;
        logic [KW-1:0] e_st;
        logic [KW-1:0] e_pr;
        logic [KW-1:0] e_rl;
        logic [KW-1:0] e_lg;
        logic          rs;
        bit            pr;
        cyc++;
        kin = key_in;
        rs  = rst_n;
        #1;
        e_pr = '0;
        e_rl = '0;
        e_lg = '0;
        for (int i = 0; i < KW; i++) begin
            if (!rs) begin
                m_s1[i]  = 1'b0;
                m_s2[i]  = 1'b0;
                m_lvl[i] = 1'b0;
                m_run[i] = 0;
                m_pt[i]  = -1000000;
            end else begin
                pr      = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = ~kin[i];
                if (m_lvl[i] && (cyc - m_pt[i] == LNG)) e_lg[i] = 1'b1;
                if (pr != m_lvl[i]) m_run[i]++;
                else                m_run[i] = 0;
                if (m_run[i] == DEB + 1) begin
                    m_run[i] = 0;
                    m_lvl[i] = ~m_lvl[i];
                    if (m_lvl[i]) begin
                        e_pr[i] = 1'b1;
                        m_pt[i] = cyc;
                    end else begin
                        e_rl[i] = 1'b1;
                    end
                end
            end
            e_st[i] = m_lvl[i];
        end
        check("outputs", {key_state, key_press, key_release, key_long}, {e_st, e_pr, e_rl, e_lg});
    end

    initial begin
        int at;
        int ap;
        int t0;

        // 1. reset then idle
        key_in = 2'b11;
        rst_n  = 1'b0;
        repeat (5) @(negedge clk_100M);
        check("reset_state", {key_state, key_press, key_release, key_long}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_100M);
        check("idle_state", key_state, 0);

        // 2. clean press, latency 2+DEB
        key_in[0] = 1'b0;
        t0 = cyc;
        wait_bit(1, 0, 40, ap);
        check("press_latency", ap - (t0 + 1), 6);
        check("press_state", key_state[0], 1);
        @(posedge clk_100M);
        #2;
        check("press_one_cycle", key_press[0], 0);

        // 4. long press: pulse LNG after press, then release latency
        wait_bit(3, 0, 40, at);
        check("long_latency", at - ap, 16);
        repeat (20) @(negedge clk_100M);
        key_in[0] = 1'b1;
        t0 = cyc;
        wait_bit(2, 0, 40, at);
        check("release_latency", at - (t0 + 1), 6);
        check("release_state", key_state[0], 0);

        // 3. bounce rejection
        repeat (5) @(negedge clk_100M);
        key_in[0] = 1'b0;
        repeat (2) @(negedge clk_100M);
        key_in[0] = 1'b1;
        repeat (2) @(negedge clk_100M);
        key_in[0] = 1'b0;
        repeat (2) @(negedge clk_100M);
        key_in[0] = 1'b1;
        repeat (20) @(negedge clk_100M);
        check("bounce_state", key_state[0], 0);

        // 5. release glitch leaves hold timing intact
        key_in[0] = 1'b0;
        wait_bit(1, 0, 40, ap);
        repeat (5) @(negedge clk_100M);
        key_in[0] = 1'b1;
        repeat (2) @(negedge clk_100M);
        key_in[0] = 1'b0;
        wait_bit(3, 0, 40, at);
        check("glitch_long_latency", at - ap, 16);
        check("glitch_state", key_state[0], 1);
        @(negedge clk_100M);
        key_in[0] = 1'b1;
        wait_bit(2, 0, 40, at);
        repeat (5) @(negedge clk_100M);

        // 6. simultaneous press, then async reset mid-debounce
        key_in = 2'b00;
        wait_bit(1, 0, 40, at);
        check("dual_press", key_press, 2'b11);
        @(negedge clk_100M);
        key_in[1] = 1'b1;
        wait_bit(2, 1, 40, at);
        @(negedge clk_100M);
        key_in[1] = 1'b0;
        repeat (4) @(negedge clk_100M);
        check("pre_reset_state", key_state, 2'b01);
        rst_n = 1'b0;
        #1;
        check("async_reset", {key_state, key_press, key_release, key_long}, 0);
        repeat (3) @(negedge clk_100M);
        key_in = 2'b11;
        rst_n  = 1'b1;
        repeat (20) @(negedge clk_100M);
        check("post_reset_state", key_state, 0);

        // Randomized segments: bouncy and stable, with rare resets.
        for (int seg = 0; seg < 40; seg++) begin
            int prob;
            prob = ($urandom_range(0, 1) == 1) ? 3 : 40;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk_100M);
                for (int k = 0; k < KW; k++) begin
                    if ($urandom_range(0, prob - 1) == 0) key_in[k] = ~key_in[k];
                end
                rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_100M);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
